// File: rtl/alu_op_decoder.sv
// Registered RV32 decode stage producing the 4-bit alu_op code, buffered in a 2-entry FIFO toward execute.
// Optional feature macro ILLEGAL_TRAP_EN: a sticky trap on illegal words that stalls intake until trap_clr.
module alu_op_decoder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_alu_op,
    output logic             out_use_imm,
    output logic             out_is_branch,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_count,
    output logic             trap,
    input  logic             trap_clr
);

    localparam int unsigned OP_W       = 4;
    localparam int unsigned FIFO_CNT_W = 2;

    localparam logic [FIFO_CNT_W-1:0] FIFO_EMPTY = FIFO_CNT_W'(0);
    localparam logic [FIFO_CNT_W-1:0] FIFO_ONE   = FIFO_CNT_W'(1);
    localparam logic [FIFO_CNT_W-1:0] FIFO_FULL  = FIFO_CNT_W'(2);

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic [OP_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [OP_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [OP_W-1:0] ALU_SL  = 4'b0010;
    localparam logic [OP_W-1:0] ALU_AND = 4'b0011;
    localparam logic [OP_W-1:0] ALU_SR  = 4'b0100;
    localparam logic [OP_W-1:0] ALU_BLT = 4'b0101;
    localparam logic [OP_W-1:0] ALU_OR  = 4'b0110;
    localparam logic [OP_W-1:0] ALU_MUL = 4'b1000;
    localparam logic [OP_W-1:0] ALU_BGT = 4'b1001;
    localparam logic [OP_W-1:0] ALU_BEQ = 4'b1100;

    typedef struct packed {
        logic [OP_W-1:0] alu_op;
        logic            use_imm;
        logic            is_branch;
        logic            illegal;
    } dec_t;

    logic [6:0] opcode_c;
    logic [2:0] funct3_c;
    logic [6:0] funct7_c;
    dec_t       dec_c;
    logic       legal_c;

    assign opcode_c = in_instr[6:0];
    assign funct3_c = in_instr[14:12];
    assign funct7_c = in_instr[31:25];

    // Register fields and rd play no part in the ALU op selection.
    logic unused_instr;
    assign unused_instr = ^{in_instr[24:15], in_instr[11:7]};

    // Instruction decode; anything not matched collapses to the illegal entry.
    always_comb begin
        dec_c   = '0;
        legal_c = 1'b0;
        case (opcode_c)
            OPC_R: begin
                legal_c = 1'b1;
                case ({funct7_c, funct3_c})
                    {F7_BASE, 3'b000}: dec_c.alu_op = ALU_ADD;
                    {F7_BASE, 3'b001}: dec_c.alu_op = ALU_SL;
                    {F7_BASE, 3'b101}: dec_c.alu_op = ALU_SR;
                    {F7_BASE, 3'b111}: dec_c.alu_op = ALU_AND;
                    {F7_BASE, 3'b110}: dec_c.alu_op = ALU_OR;
                    {F7_ALT,  3'b000}: dec_c.alu_op = ALU_SUB;
                    {F7_MUL,  3'b000}: dec_c.alu_op = ALU_MUL;
                    default:           legal_c      = 1'b0;
                endcase
            end
            OPC_I: begin
                legal_c       = 1'b1;
                dec_c.use_imm = 1'b1;
                case (funct3_c)
                    3'b000:  dec_c.alu_op = ALU_ADD;
                    3'b111:  dec_c.alu_op = ALU_AND;
                    3'b110:  dec_c.alu_op = ALU_OR;
                    3'b001: begin
                        dec_c.alu_op = ALU_SL;
                        legal_c      = (funct7_c == F7_BASE);
                    end
                    3'b101: begin
                        dec_c.alu_op = ALU_SR;
                        legal_c      = (funct7_c == F7_BASE);
                    end
                    default: legal_c = 1'b0;
                endcase
            end
            OPC_LOAD, OPC_STORE: begin
                legal_c       = 1'b1;
                dec_c.alu_op  = ALU_ADD;
                dec_c.use_imm = 1'b1;
            end
            OPC_BRANCH: begin
                legal_c         = 1'b1;
                dec_c.is_branch = 1'b1;
                case (funct3_c)
                    3'b000:  dec_c.alu_op = ALU_BEQ;
                    3'b110:  dec_c.alu_op = ALU_BLT;
                    3'b111:  dec_c.alu_op = ALU_BGT;
                    default: legal_c      = 1'b0;
                endcase
            end
            default: legal_c = 1'b0;
        endcase
        if (!legal_c) begin
            dec_c         = '0;
            dec_c.illegal = 1'b1;
        end
    end

    dec_t                  head_q, head_d;
    dec_t                  tail_q, tail_d;
    logic [FIFO_CNT_W-1:0] count_q, count_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [CNT_W-1:0]      ill_cnt_q, ill_cnt_d;
    logic                  trap_q, trap_d;
    logic                  push_c;
    logic                  pop_c;

    assign push_c = in_valid & in_ready_q;
    assign pop_c  = out_valid_q & out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= FIFO_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            ill_cnt_q   <= '0;
            trap_q      <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            ill_cnt_q   <= ill_cnt_d;
            trap_q      <= trap_d;
        end
    end

    // Next state: FIFO movement, saturating counter, trap, and registered handshakes.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q + FIFO_CNT_W'(push_c) - FIFO_CNT_W'(pop_c);
        ill_cnt_d = ill_cnt_q;
        trap_d    = 1'b0;

        // The head doubles as the output register, so it keeps its value when the FIFO empties.
        if (pop_c) begin
            if (count_q == FIFO_FULL) begin
                head_d = tail_q;
            end else if (push_c) begin
                head_d = dec_c;
            end
        end else if (push_c) begin
            if (count_q == FIFO_EMPTY) begin
                head_d = dec_c;
            end else begin
                tail_d = dec_c;
            end
        end

        if (push_c && dec_c.illegal && (ill_cnt_q != {CNT_W{1'b1}})) begin
            ill_cnt_d = ill_cnt_q + CNT_W'(1);
        end

`ifdef ILLEGAL_TRAP_EN
        trap_d = trap_q;
        if (trap_clr) begin
            trap_d = 1'b0;
        end
        if (push_c && dec_c.illegal) begin
            trap_d = 1'b1;
        end
`endif

        in_ready_d  = (count_d != FIFO_FULL) && !trap_d;
        out_valid_d = (count_d != FIFO_EMPTY);
    end

`ifndef ILLEGAL_TRAP_EN
    logic unused_trap_clr;
    assign unused_trap_clr = trap_clr;
`endif

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_alu_op    = head_q.alu_op;
    assign out_use_imm   = head_q.use_imm;
    assign out_is_branch = head_q.is_branch;
    assign out_illegal   = head_q.illegal;
    assign illegal_count = ill_cnt_q;
    assign trap          = trap_q;

    // FIFO_ONE names the single-entry occupancy for readability in waveforms.
    logic unused_one;
    assign unused_one = ^FIFO_ONE;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Scoreboard bench for alu_op_decoder: directed RV32 words with hand-decoded expectations.
module tb_alu_op_decoder;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_alu_op;
    logic          out_use_imm;
    logic          out_is_branch;
    logic          out_illegal;
    logic [CW-1:0] illegal_count;
    logic          trap;
    logic          trap_clr;

    alu_op_decoder #(.CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_alu_op    (out_alu_op),
        .out_use_imm   (out_use_imm),
        .out_is_branch (out_is_branch),
        .out_illegal   (out_illegal),
        .illegal_count (illegal_count),
        .trap          (trap),
        .trap_clr      (trap_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] op;
        logic       imm;
        logic       br;
        logic       ill;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   auto_clr = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: a head entry seen with out_ready high at the falling edge pops on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'({out_alu_op, out_use_imm, out_is_branch, out_illegal}), 32'hFFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_entry", 32'({out_alu_op, out_use_imm, out_is_branch, out_illegal}),
                      32'({e.op, e.imm, e.br, e.ill}));
            end
        end
    end

    task automatic push_word(input logic [31:0] w, input logic [3:0] op,
                             input logic imm, input logic br, input logic ill);
        int waits;
        waits    = 0;
        in_valid = 1'b1;
        in_instr = w;
        @(negedge clk);
        while (!in_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        check("push_accept", 32'(in_ready), 32'd1);
        if (in_ready) exp_q.push_back('{op: op, imm: imm, br: br, ill: ill});
        @(posedge clk); #1;
        in_valid = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        if (ill && auto_clr) begin
            trap_clr = 1'b1;
            @(posedge clk); #1;
            trap_clr = 1'b0;
        end
`endif
    endtask

    task automatic drain();
        int waits;
        waits = 0;
        while (exp_q.size() != 0 && waits < 40) begin
            waits++;
            @(negedge clk);
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b0;
        trap_clr  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_fields", 32'({out_alu_op, out_use_imm, out_is_branch, out_illegal}), 32'd0);
        check("rst_ill_cnt", 32'(illegal_count), 32'd0);
        check("rst_trap", 32'(trap), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // R-type basics and one-cycle latency.
        out_ready = 1'b1;
        push_word(32'h00B50533, 4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("latency_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        push_word(32'h40B50533, 4'b0001, 1'b0, 1'b0, 1'b0);
        push_word(32'h02B50533, 4'b1000, 1'b0, 1'b0, 1'b0);
        push_word(32'h00B56533, 4'b0110, 1'b0, 1'b0, 1'b0);
        push_word(32'h00B55533, 4'b0100, 1'b0, 1'b0, 1'b0);
        // Immediate, memory and branch forms.
        push_word(32'h00150513, 4'b0000, 1'b1, 1'b0, 1'b0);
        push_word(32'h00151513, 4'b0010, 1'b1, 1'b0, 1'b0);
        push_word(32'h00157513, 4'b0011, 1'b1, 1'b0, 1'b0);
        push_word(32'h00156513, 4'b0110, 1'b1, 1'b0, 1'b0);
        push_word(32'h00052503, 4'b0000, 1'b1, 1'b0, 1'b0);
        push_word(32'h00B52023, 4'b0000, 1'b1, 1'b0, 1'b0);
        push_word(32'h00B56463, 4'b0101, 1'b0, 1'b1, 1'b0);
        push_word(32'h00B57463, 4'b1001, 1'b0, 1'b1, 1'b0);
        push_word(32'h00B50463, 4'b1100, 1'b0, 1'b1, 1'b0);
        drain();
        repeat (2) @(negedge clk);
        check("empty_valid", 32'(out_valid), 32'd0);
        check("empty_hold_op", 32'(out_alu_op), 32'hC);
        check("ill_cnt_legal", 32'(illegal_count), 32'd0);

        // Full FIFO with out_ready low: third word is held until a single pop.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00B57533;
        @(negedge clk);
        check("b2b_accept1", 32'(in_ready), 32'd1);
        exp_q.push_back('{op: 4'b0011, imm: 1'b0, br: 1'b0, ill: 1'b0});
        @(posedge clk); #1;
        in_instr = 32'h00B56533;
        @(negedge clk);
        check("b2b_accept2", 32'(in_ready), 32'd1);
        exp_q.push_back('{op: 4'b0110, imm: 1'b0, br: 1'b0, ill: 1'b0});
        @(posedge clk); #1;
        in_instr = 32'h00B55533;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("b2b_full_ready", 32'(in_ready), 32'd0);
            check("b2b_full_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("b2b_reopen", 32'(in_ready), 32'd1);
        exp_q.push_back('{op: 4'b0100, imm: 1'b0, br: 1'b0, ill: 1'b0});
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Illegal words and counter saturation (counter is 4 bits wide here).
        @(posedge clk); #1;
        push_word(32'hFFFFFFFF, 4'b0000, 1'b0, 1'b0, 1'b1);
        push_word(32'h00001063, 4'b0000, 1'b0, 1'b0, 1'b1);
        drain();
        check("ill_cnt_two", 32'(illegal_count), 32'd2);
        check("trap_default", 32'(trap), 32'd0);
        @(posedge clk); #1;
        push_word(32'h40155513, 4'b0000, 1'b0, 1'b0, 1'b1);
        push_word(32'h00B54533, 4'b0000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) push_word(32'hFFFFFFFF, 4'b0000, 1'b0, 1'b0, 1'b1);
        drain();
        check("ill_cnt_max", 32'(illegal_count), 32'd15);
        @(posedge clk); #1;
        push_word(32'h00000000, 4'b0000, 1'b0, 1'b0, 1'b1);
        drain();
        check("ill_cnt_sat", 32'(illegal_count), 32'd15);
`ifndef ILLEGAL_TRAP_EN
        @(posedge clk); #1;
        trap_clr = 1'b1;
        @(posedge clk); #1;
        trap_clr = 1'b0;
        check("trap_clr_ignored", 32'(trap), 32'd0);
        check("trap_no_stall", 32'(in_ready), 32'd1);
`endif

        // Asynchronous reset with two entries buffered.
        @(posedge clk); #1;
        out_ready = 1'b0;
        push_word(32'h00B50533, 4'b0000, 1'b0, 1'b0, 1'b0);
        push_word(32'h00B56533, 4'b0110, 1'b0, 1'b0, 1'b0);
        check("pre_rst_full", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_ill_cnt", 32'(illegal_count), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        push_word(32'h02B50533, 4'b1000, 1'b0, 1'b0, 1'b0);
        drain();

`ifdef ILLEGAL_TRAP_EN
        // Trap stalls intake while the illegal entry drains; trap_clr reopens it.
        @(posedge clk); #1;
        auto_clr = 1'b0;
        push_word(32'hFFFFFFFF, 4'b0000, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_instr = 32'h00B50533;
        @(negedge clk);
        check("trap_set", 32'(trap), 32'd1);
        check("trap_stall", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("trap_stall2", 32'(in_ready), 32'd0);
        check("trap_drained", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        trap_clr = 1'b1;
        @(posedge clk); #1;
        trap_clr = 1'b0;
        check("trap_cleared", 32'(trap), 32'd0);
        push_word(32'h00B50533, 4'b0000, 1'b0, 1'b0, 1'b0);
        drain();
        auto_clr = 1'b1;
`endif

        repeat (3) @(negedge clk);
        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_op_decoder.md
Name: alu_op_decoder

Overview:
- Registered decode stage that produces the 4-bit alu_op code consumed by the ALU: the producer end of the alu_op interface.
- Accepts 32-bit RV32 instruction words over a valid/ready handshake and decodes opcode/funct3/funct7 into alu_op plus side flags.
- Buffers results in a 2-entry output FIFO toward execute.
- Maintains a saturating illegal-instruction counter.

Parameters:
- CNT_W, 16, width of illegal_count.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  instruction word valid
- in_ready  output  1  decoder can accept a word this cycle
- in_instr  input  32  RV32 instruction word
- out_valid  output  1  head FIFO entry valid
- out_ready  input  1  consumer takes head entry
- out_alu_op  output  4  ALU operation code
- out_use_imm  output  1  operand b is the immediate
- out_is_branch  output  1  result is a branch compare; the ALU branch output is meaningful
- out_illegal  output  1  word was not decodable
- illegal_count  output  CNT_W  number of illegal words accepted, saturating
- trap  output  1  sticky illegal trap (ILLEGAL_TRAP_EN only)
- trap_clr  input  1  clears trap (ILLEGAL_TRAP_EN only)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - FIFO count 0; out_valid=0, in_ready=1.
  - out_alu_op=4'b0000; out_use_imm, out_is_branch, out_illegal = 0.
  - illegal_count=0; trap=0.
  - Reset mid-transfer discards all buffered entries.
- alu_op codes: ADD 0000, SUB 0001, SL 0010, AND 0011, SR 0100, BLT 0101, OR 0110, MUL 1000, BGT 1001, BEQ 1100.
- Decode, purely from in_instr:
  - opcode 0110011 (R-type):
    - funct7 0000000 with funct3 000/001/101/111/110 gives ADD/SL/SR/AND/OR.
    - funct7 0100000 with funct3 000 gives SUB.
    - funct7 0000001 with funct3 000 gives MUL.
    - Any other combination is illegal.
  - opcode 0010011 (I-type), use_imm=1:
    - funct3 000/111/110 gives ADD/AND/OR.
    - funct3 001 and 101 give SL/SR, but only with instr[31:25]=0000000; otherwise illegal.
    - Any other funct3 is illegal.
  - opcode 0000011 (load) or 0100011 (store): ADD, use_imm=1.
  - opcode 1100011 (branch), is_branch=1:
    - funct3 000/110/111 gives BEQ/BLT/BGT (team subset; unsigned compares).
    - Any other funct3 is illegal.
  - Any other opcode is illegal.
  - An illegal entry carries out_alu_op=0000, use_imm=0, is_branch=0, illegal=1.
- Handshake and latency:
  - Push when in_valid & in_ready. Pop when out_valid & out_ready.
  - Latency is 1: a word accepted in cycle N appears at the head with out_valid=1 in cycle N+1 if the FIFO was empty.
  - Entries leave in order.
  - in_ready = (count<2), from registered state only. There is no combinational path from out_ready to in_ready.
  - out_* fields are stable while out_valid=1 and out_ready=0.
- FIFO boundaries:
  - Empty: out_valid=0 and out_* hold their last values.
  - count=1 with simultaneous push and pop: count stays 1 and the new entry becomes the head next cycle.
  - count=2: in_ready=0. A pop alone drops count to 1, and in_ready rises the following cycle.
  - in_valid while in_ready=0 is ignored; the producer must hold the word.
- illegal_count:
  - Increments on each accepted illegal word.
  - Saturates at all-ones and never wraps.
  - Cleared only by reset.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - Accepting an illegal word sets trap=1 the next cycle.
  - While trap=1, in_ready=0 regardless of FIFO count. Already-buffered entries, including the illegal one, still drain.
  - trap_clr=1 clears trap on the next edge.
  - If trap_clr coincides with a new illegal accept, trap stays 1.
- Undefined: trap is tied to 0, trap_clr is ignored, and illegal words flow through with only out_illegal=1.

Test Plan:
- Reset, then push ADD (0x00B50533) with out_ready=1: next cycle out_valid=1, out_alu_op=0000, use_imm=0; SUB (0x40B50533) gives 0001; MUL (0x02B50533) gives 1000.
- Push ADDI 0x00150513, SLLI 0x00151513, BEQ 0x00B50463: alu_op 0000/0010/1100, use_imm 1/1/0, is_branch 0/0/1.
- Hold out_ready=0 and push 3 words back-to-back: in_ready drops after 2 accepts and the 3rd is held. Then pulse out_ready for 1 cycle: in_ready returns next cycle, and order is preserved.
- Push 0xFFFFFFFF and 0x00001063 (BNE): out_illegal=1, alu_op=0000, illegal_count=2. Force the counter to all-ones, push one more illegal word: it stays all-ones.
- Assert rst_n=0 asynchronously with 2 entries buffered: out_valid=0, in_ready=1, and illegal_count=0 immediately, without waiting for a clock edge.
- With ILLEGAL_TRAP_EN defined, push illegal then legal: trap=1 and in_ready=0 while the illegal entry still drains. Pulse trap_clr: trap=0, and the legal word is then accepted.
